wb_mem_responder: RTL and testbench

- Wishbone B3 slave memory model: the responding end of the bus that the bench's Wishbone master driver initiates transfers on.
- Stands in for the SDRAM controller's host port. Used to check the master driver, monitors and scoreboard in isolation, and to serve as a golden reference memory.
- Supports classic cycles and incrementing bursts (cti), byte lanes, programmable wait states and out-of-range error termination.

---
 rtl/wb_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_wb_mem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_responder.sv
// -----------------------------------------------------------------------------
// wb_mem_responder
//
// Wishbone B3 slave memory model. Answers classic cycles and incrementing
// bursts against an internal word array, with byte lanes, a programmable
// number of wait states before the first beat of each transfer, and error
// termination for addresses beyond the array.
//
// Handshake: a request is wb_cyc_i & wb_stb_i high at a rising edge. A beat
// terminates at the rising edge where wb_cyc_i & wb_stb_i & (wb_ack_o |
// wb_err_o) are all high; wb_ack_o/wb_err_o are combinational from the state
// and the live strobe, so the master must hold address/data/sel/we until that
// edge. wb_stb_i low inside a burst is a master wait; wb_cyc_i low anywhere
// aborts the transfer.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i   bus cycle / strobe
//   wb_we_i              1 = write, 0 = read
//   wb_addr_i [AW]       byte address, word index = wb_addr_i[DEPTH_LOG2+1:2]
//   wb_dat_i  [DW]       write data
//   wb_sel_i  [DW/8]     byte enables
//   wb_cti_i  [3]        000 classic, 010 incrementing burst, 111 end of burst
//   cfg_wait  [4]        wait states before the first beat
//   wb_ack_o, wb_err_o   normal / error beat termination
//   wb_dat_o  [DW]       read data (zero unless wb_ack_o)
//   stat_beats [16]      count of acked beats, wraps
//   dbg_state [3]        current FSM state (0 IDLE,1 WAIT,2 RESP,3 BURST,4 GAP)
// -----------------------------------------------------------------------------
module wb_mem_responder #(
    parameter int DW         = 32,
    parameter int AW         = 26,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [AW-1:0]      wb_addr_i,
    input  logic [DW-1:0]      wb_dat_i,
    input  logic [DW/8-1:0]    wb_sel_i,
    input  logic [2:0]         wb_cti_i,
    input  logic [3:0]         cfg_wait,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic [DW-1:0]      wb_dat_o,
    output logic [15:0]        stat_beats,
    output logic [2:0]         dbg_state
);

    localparam int SW    = DW / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        RESP  = 3'd2,
        BURST = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [DW-1:0]           mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   index;
    logic                    out_of_range;
    logic                    beat;
    logic                    ack_beat;
    logic                    err_beat;
    logic                    unused_addr_bits;

    assign index        = wb_addr_i[DEPTH_LOG2+1:2];
    assign out_of_range = |wb_addr_i[AW-1:DEPTH_LOG2+2];

    // A beat can only terminate in RESP or BURST; the live strobe decides it.
    assign beat     = ((state == RESP) || (state == BURST)) && wb_cyc_i && wb_stb_i;
    assign ack_beat = beat && !out_of_range;
    assign err_beat = beat && out_of_range;

    assign wb_ack_o  = ack_beat;
    assign wb_err_o  = err_beat;
    assign wb_dat_o  = ack_beat ? mem[index] : '0;
    assign dbg_state = state;

    // Byte offset bits are irrelevant to a word-wide memory.
    assign unused_addr_bits = ^wb_addr_i[1:0];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            stat_beats <= '0;
        end else begin
            if (ack_beat) begin
                stat_beats <= stat_beats + 16'd1;
            end

            if (!wb_cyc_i) begin
                // Abort: whatever beat was pending is dropped.
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (wb_stb_i) begin
                            // cfg_wait is sampled only here; later changes
                            // do not affect the transfer in flight.
                            if (cfg_wait == 4'd0) begin
                                state <= RESP;
                            end else begin
                                cnt   <= cfg_wait;
                                state <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state <= RESP;
                        end
                    end
                    RESP: begin
                        if (wb_stb_i) begin
                            if ((wb_cti_i == 3'b010) && !out_of_range) begin
                                state <= BURST;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end
                    BURST: begin
                        if (wb_stb_i && ((wb_cti_i == 3'b111) || (wb_cti_i == 3'b000)
                                         || out_of_range)) begin
                            state <= GAP;
                        end
                    end
                    GAP: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Memory has no reset so contents survive a mid-transfer reset.
    always_ff @(posedge wb_clk_i) begin
        if (ack_beat && wb_we_i) begin
            for (int b = 0; b < SW; b++) begin
                if (wb_sel_i[b]) begin
                    mem[index][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_wb_mem_responder
//
// Directed bench for wb_mem_responder: classic transfers, byte lanes, wait
// states, bursts with a master wait, error termination, abort and reset.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge (or 1 unit after a rising edge).
// -----------------------------------------------------------------------------
module tb_wb_mem_responder;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_BURST = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [25:0] addr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [3:0]  cfg_wait;
    logic        ack;
    logic        err;
    logic [31:0] dat_r;
    logic [15:0] stat_beats;
    logic [2:0]  dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] wdata [8];
    logic [31:0] rdata [8];
    logic [31:0] exp_q [$];

    wb_mem_responder #(.DW(32), .AW(26), .DEPTH_LOG2(10)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_addr_i  (addr),
        .wb_dat_i   (dat_w),
        .wb_sel_i   (sel),
        .wb_cti_i   (cti),
        .cfg_wait   (cfg_wait),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .wb_dat_o   (dat_r),
        .stat_beats (stat_beats),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Classic single transfer. Called 1 unit after a rising edge with the
    // slave in IDLE. lat = index of the terminating edge counted from the
    // request edge (0 if nothing terminated within the budget).
    task automatic wb_single(input logic w, input logic [25:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [3:0] cfg_next,
                             output int lat, output logic got_ack, output logic got_err,
                             output logic [31:0] rd, output logic term_next);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; dat_w = d; sel = s; cti = 3'b000;
        lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0; term_next = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) cfg_wait = cfg_next;
            @(negedge clk);
            if (ack || err) begin
                lat = i; got_ack = ack; got_err = err; rd = dat_r;
                break;
            end
        end
        @(posedge clk); #1;
        term_next = ack | err;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    // Burst of n beats from base; stb drops for one cycle after beat
    // gap_after. Stops early on an error beat.
    task automatic wb_burst(input logic w, input logic [25:0] base, input int n,
                            input int gap_after, output int acks, output int errs,
                            output int gap_hits, output logic [2:0] end_state);
        logic got;
        acks = 0; errs = 0; gap_hits = 0; end_state = S_IDLE;
        cyc = 1'b1;
        for (int k = 0; k < n; k++) begin
            got = 1'b0;
            stb = 1'b1; we = w; addr = base + 26'(4 * k); sel = 4'hF;
            dat_w = w ? wdata[k] : 32'h0;
            cti = (k == n - 1) ? 3'b111 : 3'b010;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (ack || err) begin
                    got = 1'b1;
                    if (ack) begin
                        acks++;
                        rdata[k] = dat_r;
                    end else begin
                        errs++;
                    end
                end
                @(posedge clk); #1;
            end
            if (!got || errs != 0) break;
            if (k == gap_after) begin
                stb = 1'b0;
                @(negedge clk);
                if (ack || err) gap_hits++;
                @(posedge clk); #1;
            end
        end
        end_state = dbg_state;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat;
        logic        got_ack;
        logic        got_err;
        logic [31:0] rd;
        logic        term_next;
        int          acks;
        int          errs;
        int          gap_hits;
        logic [2:0]  end_state;
        int          abort_hits;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0;
        dat_w = '0; sel = '0; cti = 3'b000; cfg_wait = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dat", dat_r, 32'h0);
        chk("rst_stat", 32'(stat_beats), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        rst = 1'b0;
        @(posedge clk); #1;

        // Classic write then read, no wait states.
        wb_single(1'b1, 26'h40, 32'hDEADBEEF, 4'hF, 4'd0, lat, got_ack, got_err, rd, term_next);
        chk("wr40_lat", 32'(lat), 32'd1);
        chk("wr40_ack", 32'(got_ack), 32'd1);
        chk("wr40_ack_one_cycle", 32'(term_next), 32'd0);
        wb_single(1'b0, 26'h40, 32'h0, 4'hF, 4'd0, lat, got_ack, got_err, rd, term_next);
        chk("rd40_lat", 32'(lat), 32'd1);
        chk("rd40_data", rd, 32'hDEADBEEF);
        chk("stat_after_classic", 32'(stat_beats), 32'd2);

        // Byte lanes.
        wb_single(1'b1, 26'h80, 32'h11223344, 4'hF, 4'd0, lat, got_ack, got_err, rd, term_next);
        wb_single(1'b1, 26'h80, 32'hAABBCCDD, 4'b0101, 4'd0, lat, got_ack, got_err, rd, term_next);
        wb_single(1'b0, 26'h80, 32'h0, 4'hF, 4'd0, lat, got_ack, got_err, rd, term_next);
        chk("bytelane_data", rd, 32'h11BB33DD);
        chk("stat_after_bytelane", 32'(stat_beats), 32'd5);

        // Wait states; cfg_wait drops to 0 during WAIT and must be ignored.
        cfg_wait = 4'd3;
        wb_single(1'b0, 26'h80, 32'h0, 4'hF, 4'd0, lat, got_ack, got_err, rd, term_next);
        chk("wait3_lat", 32'(lat), 32'd4);
        chk("wait3_ack", 32'(got_ack), 32'd1);
        chk("wait3_ack_one_cycle", 32'(term_next), 32'd0);
        chk("wait3_data", rd, 32'h11BB33DD);
        cfg_wait = 4'd0;

        // 8-beat burst write with a master wait after beat 3, then readback.
        for (int k = 0; k < 8; k++) begin
            wdata[k] = 32'hB000_0000 + 32'(k) * 32'h0101_1111;
            exp_q.push_back(wdata[k]);
        end
        wb_burst(1'b1, 26'h100, 8, 2, acks, errs, gap_hits, end_state);
        chk("bwr_acks", 32'(acks), 32'd8);
        chk("bwr_errs", 32'(errs), 32'd0);
        chk("bwr_gap_acks", 32'(gap_hits), 32'd0);
        chk("bwr_end_gap", 32'(end_state), 32'(S_GAP));
        chk("bwr_idle", 32'(dbg_state), 32'(S_IDLE));
        wb_burst(1'b0, 26'h100, 8, -1, acks, errs, gap_hits, end_state);
        chk("brd_acks", 32'(acks), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("brd_data%0d", k), rdata[k], exp_q.pop_front());
        end
        chk("stat_after_burst", 32'(stat_beats), 32'd22);

        // Out-of-range classic write must not touch word 0.
        wb_single(1'b1, 26'h0, 32'h0BADF00D, 4'hF, 4'd0, lat, got_ack, got_err, rd, term_next);
        wb_single(1'b1, 26'h100_0000, 32'h55555555, 4'hF, 4'd0, lat, got_ack, got_err, rd, term_next);
        chk("oor_lat", 32'(lat), 32'd1);
        chk("oor_err", 32'(got_err), 32'd1);
        chk("oor_no_ack", 32'(got_ack), 32'd0);
        chk("oor_dat_zero", rd, 32'h0);
        chk("stat_after_oor", 32'(stat_beats), 32'd23);
        wb_single(1'b0, 26'h0, 32'h0, 4'hF, 4'd0, lat, got_ack, got_err, rd, term_next);
        chk("oor_mem_unchanged", rd, 32'h0BADF00D);

        // Burst from the top word: ack, then err, burst over.
        wb_burst(1'b1, 26'hFFC, 4, -1, acks, errs, gap_hits, end_state);
        chk("wrap_acks", 32'(acks), 32'd1);
        chk("wrap_errs", 32'(errs), 32'd1);
        chk("wrap_end_gap", 32'(end_state), 32'(S_GAP));
        chk("stat_after_wrap", 32'(stat_beats), 32'd25);

        // Abort during WAIT.
        wb_single(1'b1, 26'h200, 32'hCAFE0001, 4'hF, 4'd0, lat, got_ack, got_err, rd, term_next);
        cfg_wait = 4'd5;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 26'h200; dat_w = 32'h12345678;
        sel = 4'hF; cti = 3'b000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_in_wait", 32'(dbg_state), 32'(S_WAIT));
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        abort_hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack || err) abort_hits++;
            @(posedge clk); #1;
        end
        chk("abort_no_ack", 32'(abort_hits), 32'd0);
        chk("abort_idle", 32'(dbg_state), 32'(S_IDLE));
        cfg_wait = 4'd0;
        wb_single(1'b0, 26'h200, 32'h0, 4'hF, 4'd0, lat, got_ack, got_err, rd, term_next);
        chk("abort_no_write", rd, 32'hCAFE0001);
        chk("stat_after_abort", 32'(stat_beats), 32'd27);

        // Reset in the middle of a burst read.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 26'h100; sel = 4'hF; cti = 3'b010;
        @(negedge clk);
        @(negedge clk);
        chk("rstb_beat0_ack", 32'(ack), 32'd1);
        @(posedge clk); #1;
        addr = 26'h104;
        @(negedge clk);
        chk("rstb_beat1_ack", 32'(ack), 32'd1);
        chk("rstb_in_burst", 32'(dbg_state), 32'(S_BURST));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstb_ack_low", 32'(ack), 32'd0);
        chk("rstb_idle", 32'(dbg_state), 32'(S_IDLE));
        chk("rstb_stat_zero", 32'(stat_beats), 32'd0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; cti = 3'b000;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
